// File: rtl/hazard_controller.sv
// Hazard/sequencing control for the 5-stage MIPS pipe: forwarding selects, load-use and
// branch stalls, and a wait-state FSM for a multi-cycle data memory with timeout.

module hazard_fwd_lane #(
   parameter int RF_ADDR_WIDTH = 5
) (
   input  logic [RF_ADDR_WIDTH-1:0] src_e,
   input  logic [RF_ADDR_WIDTH-1:0] src_d,
   input  logic [RF_ADDR_WIDTH-1:0] write_reg_m,
   input  logic [RF_ADDR_WIDTH-1:0] write_reg_w,
   input  logic                     reg_write_m,
   input  logic                     reg_write_w,
   output logic [1:0]               fwd_e,
   output logic                     fwd_d
);
   logic m_live, w_live;

   // r0 is hardwired zero, so a write to it must never be forwarded
   assign m_live = reg_write_m && (write_reg_m != '0);
   assign w_live = reg_write_w && (write_reg_w != '0);

   assign fwd_e = (m_live && (write_reg_m == src_e)) ? 2'b10 :
                  (w_live && (write_reg_w == src_e)) ? 2'b01 : 2'b00;
   assign fwd_d = m_live && (write_reg_m == src_d);
endmodule

module hazard_controller #(
   parameter int         RF_ADDR_WIDTH = 5,
   parameter logic [1:0] LOAD_SEL      = 2'b01,
   parameter int         TIMEOUT       = 16,
   parameter int         CNT_WIDTH     = 16
) (
   input  logic                     i_CLK,
   input  logic                     i_RST,
   input  logic [RF_ADDR_WIDTH-1:0] i_RsD,
   input  logic [RF_ADDR_WIDTH-1:0] i_RtD,
   input  logic [RF_ADDR_WIDTH-1:0] i_RsE,
   input  logic [RF_ADDR_WIDTH-1:0] i_RtE,
   input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegE,
   input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegM,
   input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegW,
   input  logic                     i_RegWriteE,
   input  logic                     i_RegWriteM,
   input  logic                     i_RegWriteW,
   input  logic [1:0]               i_MemtoRegE,
   input  logic [1:0]               i_MemtoRegM,
   input  logic                     i_BranchD,
   input  logic                     i_PCSrcD,
   input  logic                     i_MemReqM,
   input  logic                     i_MemReadyM,
   output logic                     o_StallF,
   output logic                     o_StallD,
   output logic                     o_StallE,
   output logic                     o_StallM,
   output logic                     o_FlushD,
   output logic                     o_FlushE,
   output logic                     o_FlushW,
   output logic [1:0]               o_ForwardAE,
   output logic [1:0]               o_ForwardBE,
   output logic                     o_ForwardAD,
   output logic                     o_ForwardBD,
   output logic [CNT_WIDTH-1:0]     o_StallCnt,
   output logic                     o_MemErr
);
   localparam int WCNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

   typedef struct packed {
      logic stall_f, stall_d, stall_e, stall_m;
      logic flush_d, flush_e, flush_w;
   } ctl_t;

   localparam ctl_t HOLD_ALL = 7'b1111_001;

   state_t              state_q, state_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic                err_q, err_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q;
   ctl_t                ctl;
   logic                memwait, lwstall, brstall, hz;

   // lane 0 = operand A (Rs), lane 1 = operand B (Rt)
   logic [1:0][RF_ADDR_WIDTH-1:0] src_e, src_d;
   logic [1:0][1:0]               fwd_e;
   logic [1:0]                    fwd_d;

   assign src_e = {i_RtE, i_RsE};
   assign src_d = {i_RtD, i_RsD};

   for (genvar g = 0; g < 2; g++) begin : g_lane
      hazard_fwd_lane #(.RF_ADDR_WIDTH(RF_ADDR_WIDTH)) u_lane (
         .src_e       (src_e[g]),
         .src_d       (src_d[g]),
         .write_reg_m (i_WriteRegM),
         .write_reg_w (i_WriteRegW),
         .reg_write_m (i_RegWriteM),
         .reg_write_w (i_RegWriteW),
         .fwd_e       (fwd_e[g]),
         .fwd_d       (fwd_d[g])
      );
   end

   assign o_ForwardAE = i_RST ? 2'b00 : fwd_e[0];
   assign o_ForwardBE = i_RST ? 2'b00 : fwd_e[1];
   assign o_ForwardAD = i_RST ? 1'b0  : fwd_d[0];
   assign o_ForwardBD = i_RST ? 1'b0  : fwd_d[1];

   assign memwait = i_MemReqM && !i_MemReadyM;
   assign lwstall = i_RegWriteE && (i_MemtoRegE == LOAD_SEL) && (i_RtE != '0) &&
                    ((i_RtE == i_RsD) || (i_RtE == i_RtD));
   // the load term deliberately ignores RegWriteM: a load in M always blocks the comparator
   assign brstall = i_BranchD &&
                    ((i_RegWriteE && (i_WriteRegE != '0) &&
                      ((i_WriteRegE == i_RsD) || (i_WriteRegE == i_RtD))) ||
                     ((i_MemtoRegM == LOAD_SEL) && (i_WriteRegM != '0) &&
                      ((i_WriteRegM == i_RsD) || (i_WriteRegM == i_RtD))));
   assign hz = lwstall || brstall;

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state_q     <= RUN;
         wcnt_q      <= '0;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         err_q   <= err_d;
         if (ctl.stall_f && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      end
   end

   // wcnt counts low-ready cycles already spent waiting; the TIMEOUT-th one trips ERROR
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      err_d   = err_q;
      unique case (state_q)
         RUN: begin
            if (memwait) begin
               state_d = MEM_WAIT;
               wcnt_d  = WCNT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (i_MemReadyM) begin
               state_d = RUN;
               wcnt_d  = '0;
            end else begin
               wcnt_d = wcnt_q + WCNT_W'(1);
               if (wcnt_q == WCNT_W'(TIMEOUT - 1)) begin
                  state_d = ERROR;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = ERROR;
      endcase
   end

   always_comb begin
      ctl = '0;
      if (!i_RST) begin
         unique case (state_q)
            RUN: begin
               if (memwait) begin
                  ctl = HOLD_ALL;
               end else begin
                  ctl.stall_f = hz;
                  ctl.stall_d = hz;
                  ctl.flush_e = hz;
                  ctl.flush_d = i_PCSrcD && !hz;
               end
            end
            default: ctl = HOLD_ALL;
         endcase
      end
   end

   assign o_StallF   = ctl.stall_f;
   assign o_StallD   = ctl.stall_d;
   assign o_StallE   = ctl.stall_e;
   assign o_StallM   = ctl.stall_m;
   assign o_FlushD   = ctl.flush_d;
   assign o_FlushE   = ctl.flush_e;
   assign o_FlushW   = ctl.flush_w;
   assign o_StallCnt = stall_cnt_q;
   assign o_MemErr   = err_q;
endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (CNT_WIDTH=4 so saturation is reachable quickly);
// expected outputs are queued when a step is driven and popped at the following negedge.

module tb_hazard_controller;
   localparam int TIMEOUT = 16;

   typedef struct packed {
      logic       rst;
      logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
      logic       rwe, rwm, rww;
      logic [1:0] mte, mtm;
      logic       br, pcs, mreq, mrdy;
   } stim_t;

   typedef struct packed {
      logic [1:0] fae, fbe;
      logic       fad, fbd;
      logic [6:0] ctl;   // {sf, sd, se, sm, fd, fe, fw}
      logic       err;
      logic [3:0] cnt;
   } obs_t;

   localparam logic [6:0] NONE = 7'b0000_000;
   localparam logic [6:0] HOLD = 7'b1111_001;
   localparam logic [6:0] STL  = 7'b1100_010;
   localparam logic [6:0] FLD  = 7'b0000_100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] RsD = '0, RtD = '0, RsE = '0, RtE = '0, WrE = '0, WrM = '0, WrW = '0;
   logic       RwE = 1'b0, RwM = 1'b0, RwW = 1'b0;
   logic [1:0] MtE = '0, MtM = '0;
   logic       BrD = 1'b0, PcsD = 1'b0, MemReq = 1'b0, MemRdy = 1'b0;

   logic       sF, sD, sE, sM, fD, fE, fW, fAD, fBD, merr;
   logic [1:0] fAE, fBE;
   logic [3:0] scnt;

   stim_t      nx;
   obs_t       sb_q[$];
   string      tag_q[$];
   int         vectors = 0;
   int         miscompares = 0;
   logic [3:0] exp_cnt = '0;
   logic       exp_err = 1'b0;

   hazard_controller #(.RF_ADDR_WIDTH(5), .LOAD_SEL(2'b01), .TIMEOUT(TIMEOUT), .CNT_WIDTH(4)) dut (
      .i_CLK(clk), .i_RST(rst),
      .i_RsD(RsD), .i_RtD(RtD), .i_RsE(RsE), .i_RtE(RtE),
      .i_WriteRegE(WrE), .i_WriteRegM(WrM), .i_WriteRegW(WrW),
      .i_RegWriteE(RwE), .i_RegWriteM(RwM), .i_RegWriteW(RwW),
      .i_MemtoRegE(MtE), .i_MemtoRegM(MtM),
      .i_BranchD(BrD), .i_PCSrcD(PcsD), .i_MemReqM(MemReq), .i_MemReadyM(MemRdy),
      .o_StallF(sF), .o_StallD(sD), .o_StallE(sE), .o_StallM(sM),
      .o_FlushD(fD), .o_FlushE(fE), .o_FlushW(fW),
      .o_ForwardAE(fAE), .o_ForwardBE(fBE), .o_ForwardAD(fAD), .o_ForwardBD(fBD),
      .o_StallCnt(scnt), .o_MemErr(merr)
   );

   always #5 clk = ~clk;

   function automatic obs_t mk(input logic [1:0] fae, input logic [1:0] fbe,
                               input logic fad, input logic fbd, input logic [6:0] ctl);
      obs_t o;
      o.fae = fae; o.fbe = fbe; o.fad = fad; o.fbd = fbd; o.ctl = ctl;
      o.err = 1'b0; o.cnt = '0;
      return o;
   endfunction

   task automatic step(input string tag, input obs_t e);
      obs_t got, want;
      string t;
      @(posedge clk); #1;
      rst = nx.rst; RsD = nx.rsd; RtD = nx.rtd; RsE = nx.rse; RtE = nx.rte;
      WrE = nx.wre; WrM = nx.wrm; WrW = nx.wrw;
      RwE = nx.rwe; RwM = nx.rwm; RwW = nx.rww; MtE = nx.mte; MtM = nx.mtm;
      BrD = nx.br; PcsD = nx.pcs; MemReq = nx.mreq; MemRdy = nx.mrdy;
      e.err = exp_err;
      e.cnt = exp_cnt;
      sb_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
      got  = {fAE, fBE, fAD, fBD, sF, sD, sE, sM, fD, fE, fW, merr, scnt};
      want = sb_q.pop_front();
      t    = tag_q.pop_front();
      vectors++;
      assert (got === want) else begin
         miscompares++;
         $error("FAIL %s observed=%05h expected=%05h", t, got, want);
      end
      // counter advances at the next edge when this cycle stalls F
      if (want.ctl[6] && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
   endtask

   initial begin
      nx = '0;
      nx.rst = 1'b1; nx.rwm = 1'b1; nx.wrm = 5'd3; nx.rse = 5'd3;
      step("reset_outputs", mk(2'b00, 2'b00, 0, 0, NONE));

      nx = '0;
      step("idle", mk(2'b00, 2'b00, 0, 0, NONE));

      nx = '0; nx.rwm = 1; nx.wrm = 5'd3; nx.rww = 1; nx.wrw = 5'd3; nx.rse = 5'd3;
      step("fwd_ae_mem_prio", mk(2'b10, 2'b00, 0, 0, NONE));

      nx = '0; nx.rwm = 1; nx.wrm = 5'd5; nx.rww = 1; nx.wrw = 5'd6; nx.rse = 5'd5; nx.rte = 5'd6;
      step("fwd_be_wb", mk(2'b10, 2'b01, 0, 0, NONE));

      nx = '0; nx.rwm = 1; nx.rww = 1;
      step("fwd_r0", mk(2'b00, 2'b00, 0, 0, NONE));

      nx = '0; nx.wrm = 5'd7; nx.rse = 5'd7;
      step("fwd_no_regwrite", mk(2'b00, 2'b00, 0, 0, NONE));

      nx = '0; nx.rwe = 1; nx.mte = 2'b01; nx.rte = 5'd2; nx.wre = 5'd2; nx.rsd = 5'd2; nx.rtd = 5'd1;
      step("lw_stall", mk(2'b00, 2'b00, 0, 0, STL));

      nx = '0; nx.rww = 1; nx.wrw = 5'd2; nx.rse = 5'd2;
      step("lw_then_fwd_wb", mk(2'b01, 2'b00, 0, 0, NONE));

      nx = '0; nx.rwe = 1; nx.mte = 2'b01; nx.pcs = 1;
      step("lw_rt0_no_stall", mk(2'b00, 2'b00, 0, 0, FLD));

      nx = '0; nx.rwe = 1; nx.mte = 2'b00; nx.rte = 5'd2; nx.rsd = 5'd2;
      step("not_load_no_stall", mk(2'b00, 2'b00, 0, 0, NONE));

      nx = '0; nx.br = 1; nx.pcs = 1; nx.rsd = 5'd4; nx.rwe = 1; nx.wre = 5'd4;
      step("br_stall_no_flushd", mk(2'b00, 2'b00, 0, 0, STL));

      nx = '0; nx.br = 1; nx.pcs = 1; nx.rsd = 5'd4; nx.rwm = 1; nx.wrm = 5'd4;
      step("br_fwd_taken", mk(2'b00, 2'b00, 1, 0, FLD));

      nx = '0; nx.br = 1; nx.rtd = 5'd9; nx.rwm = 1; nx.wrm = 5'd9; nx.mtm = 2'b01;
      step("br_load_in_m", mk(2'b00, 2'b00, 0, 1, STL));

      nx = '0; nx.br = 1; nx.rwe = 1;
      step("br_e_r0", mk(2'b00, 2'b00, 0, 0, NONE));

      // memory wait beats a simultaneous load-use hazard and a taken branch
      nx = '0; nx.mreq = 1; nx.rwe = 1; nx.mte = 2'b01; nx.rte = 5'd2; nx.rsd = 5'd2; nx.pcs = 1;
      step("mw_enter", mk(2'b00, 2'b00, 0, 0, HOLD));
      step("mw_wait", mk(2'b00, 2'b00, 0, 0, HOLD));
      nx.mrdy = 1;
      step("mw_ready_still_holds", mk(2'b00, 2'b00, 0, 0, HOLD));
      step("mw_hazard_reeval", mk(2'b00, 2'b00, 0, 0, STL));
      nx = '0;
      step("mw_idle_cnt", mk(2'b00, 2'b00, 0, 0, NONE));

      // ready arrives on the TIMEOUT-th cycle: back to RUN, no error
      nx = '0; nx.mreq = 1;
      for (int i = 0; i < TIMEOUT; i++) begin
         nx.mrdy = (i == TIMEOUT - 1);
         step("to_edge_wait", mk(2'b00, 2'b00, 0, 0, HOLD));
      end
      nx = '0;
      step("to_edge_run", mk(2'b00, 2'b00, 0, 0, NONE));

      nx = '0; nx.mreq = 1;
      for (int i = 0; i < TIMEOUT; i++)
         step("to_wait", mk(2'b00, 2'b00, 0, 0, HOLD));
      exp_err = 1'b1;
      nx = '0; nx.mreq = 1; nx.mrdy = 1;
      step("err_entered", mk(2'b00, 2'b00, 0, 0, HOLD));
      nx = '0; nx.pcs = 1;
      step("err_sticky", mk(2'b00, 2'b00, 0, 0, HOLD));

      exp_cnt = '0; exp_err = 1'b0;
      nx = '0; nx.rst = 1; nx.mreq = 1;
      step("err_reset_clears", mk(2'b00, 2'b00, 0, 0, NONE));
      nx = '0;
      step("err_after_reset", mk(2'b00, 2'b00, 0, 0, NONE));

      nx = '0; nx.mreq = 1;
      step("rmw_enter", mk(2'b00, 2'b00, 0, 0, HOLD));
      step("rmw_wait", mk(2'b00, 2'b00, 0, 0, HOLD));
      exp_cnt = '0;
      nx.rst = 1;
      step("rmw_reset", mk(2'b00, 2'b00, 0, 0, NONE));
      nx = '0; nx.mreq = 1; nx.mrdy = 1;
      step("rmw_back_in_run", mk(2'b00, 2'b00, 0, 0, NONE));

      nx = '0; nx.rwe = 1; nx.mte = 2'b01; nx.rte = 5'd8; nx.rtd = 5'd8;
      for (int i = 0; i < 20; i++)
         step("stallcnt_sat", mk(2'b00, 2'b00, 0, 0, STL));
      nx = '0;
      step("stallcnt_final", mk(2'b00, 2'b00, 0, 0, NONE));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
